// File: rtl/tiny_pairing_ctrl.sv
// Host-side sequencer for the tiny Tate pairing core: loads one job, runs the core, streams six result words.
// Optional watchdog on the RUN phase is enabled by defining TINY_CTRL_TIMEOUT_EN.
module tiny_pairing_ctrl #(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd4000000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         job_valid,
  output logic         job_ready,
  input  logic [193:0] job_xp,
  input  logic [193:0] job_yp,
  input  logic [193:0] job_xq,
  input  logic [193:0] job_yq,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [193:0] res_data,
  output logic [2:0]   res_idx,
  output logic         res_last,
  output logic         busy,
  output logic         err,
  output logic         core_reset,
  output logic         core_sel,
  output logic         core_w,
  output logic [5:0]   core_addr,
  output logic [197:0] core_data,
  input  logic [197:0] core_out,
  input  logic         core_done
);

  typedef enum logic [2:0] {IDLE, LOAD, RUN, RD_ADDR, RD_CAP, RD_OUT} state_t;

  state_t       state_reg, state_next;
  logic [1:0]   cnt_reg, cnt_next;
  logic [2:0]   k_reg, k_next;
  logic         done_q;
  logic [193:0] yp_reg, yp_next, xq_reg, xq_next, yq_reg, yq_next;
  logic         res_valid_reg, res_valid_next;
  logic [193:0] res_data_reg, res_data_next;
  logic [2:0]   res_idx_reg, res_idx_next;
  logic         res_last_reg, res_last_next;
  logic         err_reg, err_next;
  logic         core_reset_reg, core_reset_next;
  logic         core_sel_reg, core_sel_next;
  logic         core_w_reg, core_w_next;
  logic [5:0]   core_addr_reg, core_addr_next;
  logic [197:0] core_data_reg, core_data_next;

`ifdef TINY_CTRL_TIMEOUT_EN
  logic [23:0]  tcnt_reg, tcnt_next;
  logic         unused_core_bits;
  assign unused_core_bits = ^core_out[197:194];
`else
  logic         unused_bits;
  assign unused_bits = ^{core_out[197:194], TIMEOUT_CYCLES};
`endif

  assign job_ready  = (state_reg == IDLE);
  assign busy       = (state_reg != IDLE);
  assign res_valid  = res_valid_reg;
  assign res_data   = res_data_reg;
  assign res_idx    = res_idx_reg;
  assign res_last   = res_last_reg;
  assign err        = err_reg;
  assign core_reset = core_reset_reg;
  assign core_sel   = core_sel_reg;
  assign core_w     = core_w_reg;
  assign core_addr  = core_addr_reg;
  assign core_data  = core_data_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      cnt_reg        <= 2'd0;
      k_reg          <= 3'd0;
      done_q         <= 1'b0;
      yp_reg         <= '0;
      xq_reg         <= '0;
      yq_reg         <= '0;
      res_valid_reg  <= 1'b0;
      res_data_reg   <= '0;
      res_idx_reg    <= 3'd0;
      res_last_reg   <= 1'b0;
      err_reg        <= 1'b0;
      core_reset_reg <= 1'b1;
      core_sel_reg   <= 1'b0;
      core_w_reg     <= 1'b0;
      core_addr_reg  <= 6'd0;
      core_data_reg  <= '0;
`ifdef TINY_CTRL_TIMEOUT_EN
      tcnt_reg       <= 24'd0;
`endif
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      k_reg          <= k_next;
      done_q         <= core_done;
      yp_reg         <= yp_next;
      xq_reg         <= xq_next;
      yq_reg         <= yq_next;
      res_valid_reg  <= res_valid_next;
      res_data_reg   <= res_data_next;
      res_idx_reg    <= res_idx_next;
      res_last_reg   <= res_last_next;
      err_reg        <= err_next;
      core_reset_reg <= core_reset_next;
      core_sel_reg   <= core_sel_next;
      core_w_reg     <= core_w_next;
      core_addr_reg  <= core_addr_next;
      core_data_reg  <= core_data_next;
`ifdef TINY_CTRL_TIMEOUT_EN
      tcnt_reg       <= tcnt_next;
`endif
    end
  end

  // Registered outputs are computed for the state being entered, so they line up with that state.
  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    k_next          = k_reg;
    yp_next         = yp_reg;
    xq_next         = xq_reg;
    yq_next         = yq_reg;
    res_valid_next  = res_valid_reg;
    res_data_next   = res_data_reg;
    res_idx_next    = res_idx_reg;
    res_last_next   = res_last_reg;
    err_next        = err_reg;
    core_reset_next = core_reset_reg;
    core_sel_next   = core_sel_reg;
    core_w_next     = core_w_reg;
    core_addr_next  = core_addr_reg;
    core_data_next  = core_data_reg;
`ifdef TINY_CTRL_TIMEOUT_EN
    tcnt_next       = tcnt_reg;
`endif

    case (state_reg)
      IDLE: begin
        if (job_valid) begin
          state_next      = LOAD;
          cnt_next        = 2'd0;
          err_next        = 1'b0;
          yp_next         = job_yp;
          xq_next         = job_xq;
          yq_next         = job_yq;
          core_reset_next = 1'b1;
          core_sel_next   = 1'b1;
          core_w_next     = 1'b1;
          core_addr_next  = 6'd3;
          core_data_next  = {4'b0, job_xp};
        end
      end

      LOAD: begin
        cnt_next = cnt_reg + 2'd1;
        case (cnt_reg)
          2'd0: begin
            core_addr_next = 6'd5;
            core_data_next = {4'b0, yp_reg};
          end
          2'd1: begin
            core_addr_next = 6'd6;
            core_data_next = {4'b0, xq_reg};
          end
          2'd2: begin
            core_addr_next = 6'd7;
            core_data_next = {4'b0, yq_reg};
          end
          default: begin
            state_next      = RUN;
            core_reset_next = 1'b0;
            core_sel_next   = 1'b0;
            core_w_next     = 1'b0;
`ifdef TINY_CTRL_TIMEOUT_EN
            tcnt_next       = 24'd0;
`endif
          end
        endcase
      end

      RUN: begin
        // Only a fresh rising edge counts; a done level left over from an earlier run is ignored.
        if (core_done && !done_q) begin
          state_next     = RD_ADDR;
          k_next         = 3'd0;
          core_sel_next  = 1'b1;
          core_w_next    = 1'b0;
          core_addr_next = 6'd9;
        end
`ifdef TINY_CTRL_TIMEOUT_EN
        else if (tcnt_reg == TIMEOUT_CYCLES - 24'd1) begin
          state_next      = IDLE;
          err_next        = 1'b1;
          core_reset_next = 1'b1;
        end else begin
          tcnt_next = tcnt_reg + 24'd1;
        end
`endif
      end

      RD_ADDR: begin
        state_next = RD_CAP;
      end

      RD_CAP: begin
        state_next     = RD_OUT;
        res_valid_next = 1'b1;
        res_data_next  = core_out[193:0];
        res_idx_next   = k_reg;
        res_last_next  = (k_reg == 3'd5);
        core_sel_next  = 1'b0;
      end

      RD_OUT: begin
        if (res_ready) begin
          res_valid_next = 1'b0;
          res_last_next  = 1'b0;
          if (k_reg == 3'd5) begin
            state_next      = IDLE;
            core_reset_next = 1'b1;
          end else begin
            state_next     = RD_ADDR;
            k_next         = k_reg + 3'd1;
            core_sel_next  = 1'b1;
            core_addr_next = 6'd9 + {3'd0, k_reg + 3'd1};
          end
        end
      end

      default: state_next = IDLE;
    endcase
  end

endmodule
